// File: rtl/lsm_pkg.sv
// lsm_pkg: shared types and constants for the load/store-multiple sequencer.
//   lsm_op_t     : STM / LDM / PUSH / POP
//   lsm_state_t  : sequencer FSM states
//   MEM_OP_*     : 7-bit data_mem opcodes presented during each operation
//   SP_IDX/LR_IDX/PC_IDX : fixed register indices used by PUSH/POP
//   popcount9()  : number of registers in a 9-bit transfer mask
package lsm_pkg;

  typedef enum logic [1:0] {
    OP_STM  = 2'd0,
    OP_LDM  = 2'd1,
    OP_PUSH = 2'd2,
    OP_POP  = 2'd3
  } lsm_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WB    = 2'd3
  } lsm_state_t;

  localparam logic [6:0] MEM_OP_STM  = 7'b1100_000;
  localparam logic [6:0] MEM_OP_LDM  = 7'b1100_100;
  localparam logic [6:0] MEM_OP_PUSH = 7'b1011_010;
  localparam logic [6:0] MEM_OP_POP  = 7'b1011_110;

  localparam logic [3:0] SP_IDX = 4'd13;
  localparam logic [3:0] LR_IDX = 4'd14;
  localparam logic [3:0] PC_IDX = 4'd15;

  function automatic logic [3:0] popcount9(input logic [8:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 9; i++) begin
      c = c + {3'd0, m[i]};
    end
    return c;
  endfunction

  function automatic logic [6:0] mem_opcode_of(input lsm_op_t o);
    logic [6:0] r;
    case (o)
      OP_STM:  r = MEM_OP_STM;
      OP_LDM:  r = MEM_OP_LDM;
      OP_PUSH: r = MEM_OP_PUSH;
      default: r = MEM_OP_POP;
    endcase
    return r;
  endfunction

  function automatic logic op_is_load(input lsm_op_t o);
    return (o == OP_LDM) || (o == OP_POP);
  endfunction

endpackage

// File: rtl/lsm_sequencer_if.sv
// lsm_sequencer_if: data-memory port between the sequencer and data_mem.
//   mem_write_en : write strobe (initiator -> memory)
//   mem_opcode   : 7-bit operation code (initiator -> memory)
//   mem_addr     : word address (initiator -> memory)
//   mem_data     : store data (initiator -> memory)
//   mem_rdata    : load data, valid one cycle after its address (memory -> initiator)
// Modports: master = sequencer side, slave = memory side.
interface lsm_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_write_en;
  logic [6:0]        mem_opcode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_write_en, mem_opcode, mem_addr, mem_data,
    input  mem_rdata
  );

  modport slave (
    input  mem_write_en, mem_opcode, mem_addr, mem_data,
    output mem_rdata
  );
endinterface

// File: rtl/lsm_lowbit_enc.sv
// lsm_lowbit_enc: finds the lowest set bit of a 9-bit register mask.
//   mask      in  9  bits 0..7 = R0..R7, bit 8 = LR (PUSH) or PC (POP)
//   ext_is_pc in  1  bit 8 names PC rather than LR
//   idx       out 4  register index of the lowest set bit
//   valid     out 1  mask is non-zero
module lsm_lowbit_enc
  import lsm_pkg::*;
(
  input  logic [8:0] mask,
  input  logic       ext_is_pc,
  output logic [3:0] idx,
  output logic       valid
);

  // One-hot of the lowest set bit: a bit wins when nothing below it is set.
  logic [8:0] onehot;

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_low
      if (gi == 0) begin : g_first
        assign onehot[gi] = mask[0];
      end else begin : g_rest
        assign onehot[gi] = mask[gi] & ~(|mask[gi-1:0]);
      end
    end
  endgenerate

  assign valid = |mask;

  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 4'(i);
    end
    if (onehot[8]) idx = ext_is_pc ? PC_IDX : LR_IDX;
  end

endmodule

// File: rtl/lsm_sequencer.sv
// lsm_sequencer: unrolls Thumb STM/LDM/PUSH/POP into one data-memory word
// access per cycle, owning the memory port (busy) until the base/SP update.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op           launch request (sampled in IDLE) and operation kind
//   base_reg, base_val  Rn index (STM/LDM) and current Rn/SP value
//   reg_list, reg_list_ext  R0..R7 mask; LR (PUSH) / PC (POP) include
//   busy, done, fault   status: in progress, final-cycle pulse, alignment fault
//   mem                 data-memory port (lsm_sequencer_if.master)
//   rf_rd_addr/rf_rd_data  combinational register-file read (store data)
//   rf_wr_en/addr/data     register-file write (load data, base writeback)
// Build option: define LSM_ALIGN_FAULT_EN to reject a misaligned base with a
// fault pulse; otherwise the low two address bits are forced to zero and
// fault is tied low.
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  lsm_op_t           op,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_val,
  input  logic [7:0]        reg_list,
  input  logic              reg_list_ext,
  output logic              busy,
  output logic              done,
  output logic              fault,
  lsm_sequencer_if.master   mem,
  output logic [3:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [3:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data
);

  lsm_state_t        state_q, state_d;
  lsm_op_t           op_q, op_d;
  logic [8:0]        list_q, list_d;         // registers still to be issued
  logic [3:0]        cur_idx_q, cur_idx_d;   // register of the word on the port now
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [6:0]        mem_opcode_q, mem_opcode_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic [3:0]        rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic              load_wr_q, load_wr_d;   // rf write data comes straight from mem_rdata
  logic              done_q, done_d;
  logic [ADDR_W-1:0] base_final_q, base_final_d;
  logic              base_wb_q, base_wb_d;
  logic [3:0]        base_idx_q, base_idx_d;
`ifdef LSM_ALIGN_FAULT_EN
  logic              fault_q, fault_d;
`endif

  // Decode of the incoming request, only meaningful while IDLE.
  logic              is_stack_in;
  logic [8:0]        mask_in;
  logic [ADDR_W-1:0] span_in;
  logic [ADDR_W-1:0] lo_addr_in;
  logic [ADDR_W-1:0] final_in;
  logic              rn_in_list;
  logic              load_q;

  assign is_stack_in = (op == OP_PUSH) || (op == OP_POP);
  assign mask_in     = {is_stack_in & reg_list_ext, reg_list};
  assign span_in     = ADDR_W'({popcount9(mask_in), 2'b00});
  // PUSH is full-descending but still transfers lowest register at lowest address.
  assign lo_addr_in  = (op == OP_PUSH) ? base_val - span_in : base_val;
  assign final_in    = (op == OP_PUSH) ? base_val - span_in : base_val + span_in;
  // LDM that loads its own base register keeps the loaded value.
  assign rn_in_list  = (op == OP_LDM) && !base_reg[3] && reg_list[base_reg[2:0]];
  assign load_q      = op_is_load(op_q);

  // One encoder serves both the launch cycle and each issue cycle.
  logic [8:0] enc_mask;
  logic       enc_pc;
  logic [3:0] enc_idx;
  logic       enc_valid;

  assign enc_mask = (state_q == ST_IDLE) ? mask_in : list_q;
  assign enc_pc   = (state_q == ST_IDLE) ? (op == OP_POP) : (op_q == OP_POP);

  lsm_lowbit_enc u_enc (
    .mask      (enc_mask),
    .ext_is_pc (enc_pc),
    .idx       (enc_idx),
    .valid     (enc_valid)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    list_d       = list_q;
    cur_idx_d    = cur_idx_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_opcode_d = mem_opcode_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = '0;
    rf_wr_data_d = '0;
    load_wr_d    = 1'b0;
    done_d       = 1'b0;
    base_final_d = base_final_q;
    base_wb_d    = base_wb_q;
    base_idx_d   = base_idx_q;
`ifdef LSM_ALIGN_FAULT_EN
    fault_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d         = op;
          mem_opcode_d = mem_opcode_of(op);
          base_final_d = final_in;
          base_idx_d   = is_stack_in ? SP_IDX : base_reg;
          base_wb_d    = enc_valid && !rn_in_list;
`ifdef LSM_ALIGN_FAULT_EN
          if (base_val[1:0] != 2'b00) begin
            base_wb_d = 1'b0;
            fault_d   = 1'b1;
            state_d   = ST_WB;
          end else
`endif
          if (!enc_valid) begin
            state_d = ST_WB;
          end else begin
            state_d    = ST_ISSUE;
            cur_idx_d  = enc_idx;
            list_d     = mask_in & (mask_in - 9'd1);
            mem_addr_d = lo_addr_in & ~ADDR_W'(3);
            mem_we_d   = !op_is_load(op);
          end
        end
      end

      ST_ISSUE: begin
        // Loaded word for the current address arrives next cycle.
        if (load_q) begin
          rf_wr_en_d   = 1'b1;
          rf_wr_addr_d = cur_idx_q;
          load_wr_d    = 1'b1;
        end
        if (enc_valid) begin
          cur_idx_d  = enc_idx;
          list_d     = list_q & (list_q - 9'd1);
          mem_addr_d = mem_addr_q + ADDR_W'(4);
          mem_we_d   = !load_q;
        end else begin
          state_d = load_q ? ST_DRAIN : ST_WB;
        end
      end

      ST_DRAIN: state_d = ST_WB;

      ST_WB: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Outputs of the WB cycle are prepared on the way in.
    if (state_d == ST_WB && state_q != ST_WB) begin
      done_d       = 1'b1;
      rf_wr_en_d   = base_wb_d;
      rf_wr_addr_d = base_idx_d;
      rf_wr_data_d = DATA_W'(base_final_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_STM;
      list_q       <= '0;
      cur_idx_q    <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_opcode_q <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      load_wr_q    <= 1'b0;
      done_q       <= 1'b0;
      base_final_q <= '0;
      base_wb_q    <= 1'b0;
      base_idx_q   <= '0;
`ifdef LSM_ALIGN_FAULT_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      list_q       <= list_d;
      cur_idx_q    <= cur_idx_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_opcode_q <= mem_opcode_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      load_wr_q    <= load_wr_d;
      done_q       <= done_d;
      base_final_q <= base_final_d;
      base_wb_q    <= base_wb_d;
      base_idx_q   <= base_idx_d;
`ifdef LSM_ALIGN_FAULT_EN
      fault_q      <= fault_d;
`endif
    end
  end

  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
`ifdef LSM_ALIGN_FAULT_EN
  assign fault            = fault_q;
`else
  assign fault            = 1'b0;
`endif
  assign mem.mem_write_en = mem_we_q;
  assign mem.mem_opcode   = mem_opcode_q;
  assign mem.mem_addr     = mem_addr_q;
  assign mem.mem_data     = rf_rd_data;
  assign rf_rd_addr       = cur_idx_q;
  assign rf_wr_en         = rf_wr_en_q;
  assign rf_wr_addr       = rf_wr_addr_q;
  assign rf_wr_data       = load_wr_q ? mem.mem_rdata : rf_wr_data_q;

endmodule

// File: tb/tb_lsm_sequencer.sv
// tb_lsm_sequencer: directed test of lsm_sequencer with a behavioural data
// memory (synchronous read) and register file. Unwritten memory words read as
// 0xA0000000|addr, unwritten registers as 0xCAFE0000|index.
module tb_lsm_sequencer;
  import lsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  lsm_op_t     op;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [7:0]  reg_list;
  logic        reg_list_ext;
  logic        busy, done, fault;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  lsm_sequencer_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  lsm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .base_reg     (base_reg),
    .base_val     (base_val),
    .reg_list     (reg_list),
    .reg_list_ext (reg_list_ext),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .mem          (mif.master),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data)
  );

  always #5 clk = ~clk;

  // ---------------- memory / register-file model ----------------
  logic [31:0] mem_arr [0:2047];
  bit          mem_vld [0:2047];
  logic [31:0] rf_arr  [0:15];
  bit          rf_vld  [0:15];

  function automatic logic [31:0] mem_now(input logic [31:0] a);
    return mem_vld[a[12:2]] ? mem_arr[a[12:2]] : (32'hA000_0000 | a);
  endfunction

  function automatic logic [31:0] rf_now(input logic [3:0] i);
    return rf_vld[i] ? rf_arr[i] : (32'hCAFE_0000 | {28'd0, i});
  endfunction

  assign rf_rd_data = rf_now(rf_rd_addr);

  always @(posedge clk) begin
    if (mif.mem_write_en) begin
      mem_arr[mif.mem_addr[12:2]] <= mif.mem_data;
      mem_vld[mif.mem_addr[12:2]] <= 1'b1;
    end
    mif.mem_rdata <= mem_now(mif.mem_addr);
    if (rf_wr_en) begin
      rf_arr[rf_wr_addr] <= rf_wr_data;
      rf_vld[rf_wr_addr] <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observations of the last operation.
  int          r_lat, r_nwr, r_nrf;
  logic [31:0] r_first, r_last, r_opc;
  logic [3:0]  r_rfa;
  logic        r_fault;

  task automatic run_op(input lsm_op_t o, input logic [3:0] br, input logic [31:0] bv,
                        input logic [7:0] rl, input logic ext);
    @(negedge clk);
    op = o; base_reg = br; base_val = bv; reg_list = rl; reg_list_ext = ext; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_lat = 0; r_nwr = 0; r_nrf = 0; r_first = '0; r_last = '0; r_rfa = '0; r_fault = 1'b0;
    r_opc = {25'd0, mif.mem_opcode};
    for (int c = 1; c <= 40; c++) begin
      if (mif.mem_write_en) begin
        if (r_nwr == 0) r_first = mif.mem_addr;
        r_last = mif.mem_addr;
        r_nwr++;
      end
      if (rf_wr_en) begin
        r_nrf++;
        r_rfa = rf_wr_addr;
      end
      if (fault) r_fault = 1'b1;
      if (done) begin
        r_lat = c;
        break;
      end
      @(negedge clk);
    end
    if (r_lat == 0) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    $display("op=%s base=0x%08h list=0x%02h ext=%0d lat=%0d mem_writes=%0d rf_writes=%0d",
             o.name(), bv, rl, ext, r_lat, r_nwr, r_nrf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr, nrf;
    rst = 1'b1; start = 1'b0; op = OP_STM; base_reg = '0; base_val = '0;
    reg_list = '0; reg_list_ext = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_mwe",   {31'd0, mif.mem_write_en}, 32'd0);
    check("rst_rfwe",  {31'd0, rf_wr_en}, 32'd0);
    check("rst_maddr", mif.mem_addr, 32'd0);
    check("rst_rfwd",  rf_wr_data, 32'd0);

    // STM R2, {R0,R1,R3} at 0x100
    run_op(OP_STM, 4'd2, 32'h100, 8'h0B, 1'b0);
    check("stm_lat",   r_lat, 32'd4);
    check("stm_nwr",   r_nwr, 32'd3);
    check("stm_first", r_first, 32'h100);
    check("stm_last",  r_last, 32'h108);
    check("stm_opc",   r_opc, 32'h60);
    check("stm_m108",  mem_now(32'h108), 32'hCAFE_0003);
    check("stm_r2",    rf_now(4'd2), 32'h10C);
    check("stm_busy",  {31'd0, busy}, 32'd0);

    // LDM R4, {R0,R4}: base reg in list -> no writeback
    run_op(OP_LDM, 4'd4, 32'h200, 8'h11, 1'b0);
    check("ldm_lat",   r_lat, 32'd4);
    check("ldm_nrf",   r_nrf, 32'd2);
    check("ldm_nwr",   r_nwr, 32'd0);
    check("ldm_opc",   r_opc, 32'h64);
    check("ldm_r0",    rf_now(4'd0), 32'hA000_0200);
    check("ldm_r4",    rf_now(4'd4), 32'hA000_0204);

    // PUSH {R0,R1,LR} with SP=0x1000
    run_op(OP_PUSH, 4'd0, 32'h1000, 8'h03, 1'b1);
    check("push_lat",   r_lat, 32'd4);
    check("push_first", r_first, 32'hFF4);
    check("push_last",  r_last, 32'hFFC);
    check("push_opc",   r_opc, 32'h5A);
    check("push_mff4",  mem_now(32'hFF4), 32'hA000_0200);
    check("push_mffc",  mem_now(32'hFFC), 32'hCAFE_000E);
    check("push_sp",    rf_now(4'd13), 32'hFF4);
    check("push_rfa",   {28'd0, r_rfa}, 32'd13);

    // POP {R0,R1,PC} with SP=0xFF4
    run_op(OP_POP, 4'd0, 32'hFF4, 8'h03, 1'b1);
    check("pop_lat", r_lat, 32'd5);
    check("pop_nrf", r_nrf, 32'd4);
    check("pop_opc", r_opc, 32'h5E);
    check("pop_r1",  rf_now(4'd1), 32'hCAFE_0001);
    check("pop_pc",  rf_now(4'd15), 32'hCAFE_000E);
    check("pop_sp",  rf_now(4'd13), 32'h1000);

    // Empty lists
    run_op(OP_STM, 4'd6, 32'h300, 8'h00, 1'b0);
    check("empty_stm_lat", r_lat, 32'd1);
    check("empty_stm_nwr", r_nwr, 32'd0);
    check("empty_stm_nrf", r_nrf, 32'd0);
    run_op(OP_LDM, 4'd6, 32'h300, 8'h00, 1'b1);
    check("empty_ldm_lat", r_lat, 32'd1);
    check("empty_ldm_nrf", r_nrf, 32'd0);

    // Reset during the second issue cycle of a 4-register STM
    @(negedge clk);
    op = OP_STM; base_reg = 4'd5; base_val = 32'h400; reg_list = 8'h0F; reg_list_ext = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nwr = 0; nrf = 0;
    for (int c = 1; c <= 2; c++) begin
      if (mif.mem_write_en) nwr++;
      if (rf_wr_en) nrf++;
      if (c == 2) rst = 1'b1;
      @(negedge clk);
    end
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_mwe",  {31'd0, mif.mem_write_en}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (mif.mem_write_en) nwr++;
      if (rf_wr_en) nrf++;
      @(negedge clk);
    end
    $display("op=STM(rst mid) base=0x00000400 list=0x0f mem_writes=%0d rf_writes=%0d", nwr, nrf);
    check("rstmid_nwr",  nwr, 32'd2);
    check("rstmid_nrf",  nrf, 32'd0);
    check("rstmid_m404", mem_now(32'h404), 32'hCAFE_0001);
    check("rstmid_m408", {31'd0, mem_vld[10'h102]}, 32'd0);
    check("rstmid_r5",   rf_now(4'd5), 32'hCAFE_0005);

    // Misaligned base
    run_op(OP_STM, 4'd2, 32'h102, 8'h03, 1'b0);
`ifdef LSM_ALIGN_FAULT_EN
    check("align_fault", {31'd0, r_fault}, 32'd1);
    check("align_lat",   r_lat, 32'd1);
    check("align_nwr",   r_nwr, 32'd0);
    check("align_nrf",   r_nrf, 32'd0);
`else
    check("align_fault", {31'd0, r_fault}, 32'd0);
    check("align_first", r_first, 32'h100);
    check("align_last",  r_last, 32'h104);
    check("align_nwr",   r_nwr, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
